// File: rtl/icache_lookup_ctrl_if.sv
// Lookup/response handshake, way tag/state inputs, lookup results and
// RAM write-enable signals of the instruction-cache lookup controller.
interface icache_lookup_ctrl_if #(
  parameter int unsigned NUM_WAYS    = 4,
  parameter int unsigned NUM_SETS    = 64,
  parameter int unsigned TAG_WIDTH   = 22,
  parameter int unsigned STATE_WIDTH = 2
);
  localparam int unsigned WB = $clog2(NUM_WAYS);
  localparam int unsigned SB = $clog2(NUM_SETS);

  logic                            req_valid;
  logic                            req_ready;
  logic [SB-1:0]                   req_set;
  logic [TAG_WIDTH-1:0]            tag_compare;
  logic [NUM_WAYS*TAG_WIDTH-1:0]   tag_ways;
  logic [NUM_WAYS*STATE_WIDTH-1:0] state_ways;
  logic                            resp_valid;
  logic                            resp_ready;
  logic                            hit;
  logic [WB-1:0]                   hit_way;
  logic [STATE_WIDTH-1:0]          hit_way_state;
  logic                            multi_hit;
  logic [NUM_WAYS-1:0]             valid;
  logic                            full;
  logic [WB-1:0]                   victim_way;
  logic                            state_tag_w_en;
  logic [SB-1:0]                   w_set;
  logic [WB-1:0]                   way;
  logic [NUM_WAYS-1:0]             w_en;
  logic                            plru_clear;

  modport master (
    output req_valid, req_set, tag_compare, tag_ways, state_ways, resp_ready,
           state_tag_w_en, w_set, way, plru_clear,
    input  req_ready, resp_valid, hit, hit_way, hit_way_state, multi_hit,
           valid, full, victim_way, w_en
  );

  modport slave (
    input  req_valid, req_set, tag_compare, tag_ways, state_ways, resp_ready,
           state_tag_w_en, w_set, way, plru_clear,
    output req_ready, resp_valid, hit, hit_way, hit_way_state, multi_hit,
           valid, full, victim_way, w_en
  );
endinterface

// File: rtl/icache_lookup_ctrl.sv
// Instruction-cache lookup controller: tag compare across ways, registered
// result with valid/ready handshake, victim selection and per-set tree-PLRU.
module icache_lookup_ctrl #(
  parameter int unsigned            NUM_WAYS    = 4,
  parameter int unsigned            NUM_SETS    = 64,
  parameter int unsigned            TAG_WIDTH   = 22,
  parameter int unsigned            STATE_WIDTH = 2,
  parameter logic [STATE_WIDTH-1:0] I           = 2'b10
) (
  input logic                 ACLK,
  input logic                 ARESETn,
  icache_lookup_ctrl_if.slave bus
);
  localparam int unsigned WB = $clog2(NUM_WAYS);
  localparam int unsigned SB = $clog2(NUM_SETS);
  localparam int unsigned NB = NUM_WAYS - 1;

  typedef logic [NB-1:0] plru_t;

  // Node n (1-based heap order, root = 1) lives at bit n-1; children 2n, 2n+1.
  // Follow each node bit toward the less recently used half.
  function automatic logic [WB-1:0] plru_pick(input plru_t bits);
    int unsigned node;
    node = 1;
    for (int unsigned l = 0; l < WB; l++) begin
      node = (node << 1) | 32'(bits[node-1]);
    end
    return WB'(node - NUM_WAYS);
  endfunction

  // Point every node on the path to way w away from w.
  function automatic plru_t plru_touch(input plru_t bits, input logic [WB-1:0] w);
    plru_t       r;
    int unsigned node;
    logic        dir;
    r    = bits;
    node = 1;
    for (int unsigned l = 0; l < WB; l++) begin
      dir         = w[WB-1-l];
      r[node-1]   = ~dir;
      node        = (node << 1) | 32'(dir);
    end
    return r;
  endfunction

  plru_t                  plru_q [NUM_SETS];

  logic                   resp_valid_q;
  logic                   hit_q;
  logic [WB-1:0]          hit_way_q;
  logic [STATE_WIDTH-1:0] hit_way_state_q;
  logic                   multi_hit_q;
  logic [NUM_WAYS-1:0]    valid_q;
  logic                   full_q;
  logic [WB-1:0]          victim_q;
  logic [SB-1:0]          resp_set_q;

  logic [NUM_WAYS-1:0]    valid_c;
  logic [NUM_WAYS-1:0]    match_c;
  logic                   hit_c;
  logic                   multi_c;
  logic [WB-1:0]          hit_way_c;
  logic [STATE_WIDTH-1:0] hit_state_c;
  logic                   full_c;
  logic [WB-1:0]          inv_way_c;
  logic [WB-1:0]          victim_c;

  logic                   accept;
  logic                   touch_hit;
  logic                   same_set;

  assign bus.req_ready     = !resp_valid_q | bus.resp_ready;
  assign accept            = bus.req_valid & bus.req_ready;
  assign touch_hit         = resp_valid_q & bus.resp_ready & hit_q;
  assign same_set          = touch_hit & bus.state_tag_w_en & (bus.w_set == resp_set_q);

  assign bus.resp_valid    = resp_valid_q;
  assign bus.hit           = hit_q;
  assign bus.hit_way       = hit_way_q;
  assign bus.hit_way_state = hit_way_state_q;
  assign bus.multi_hit     = multi_hit_q;
  assign bus.valid         = valid_q;
  assign bus.full          = full_q;
  assign bus.victim_way    = victim_q;

  // Per-way validity and tag match against the current request.
  always_comb begin
    valid_c = '0;
    match_c = '0;
    for (int unsigned k = 0; k < NUM_WAYS; k++) begin
      valid_c[k] = bus.state_ways[k*STATE_WIDTH +: STATE_WIDTH] != I;
      match_c[k] = valid_c[k] &&
                   (bus.tag_ways[k*TAG_WIDTH +: TAG_WIDTH] == bus.tag_compare);
    end
  end

  // Lowest matching way, multi-hit detection, lowest invalid way and victim.
  always_comb begin
    hit_c       = 1'b0;
    multi_c     = 1'b0;
    hit_way_c   = '0;
    hit_state_c = I;
    inv_way_c   = '0;
    for (int unsigned k = 0; k < NUM_WAYS; k++) begin
      if (match_c[k]) begin
        if (hit_c) begin
          multi_c = 1'b1;
        end else begin
          hit_c       = 1'b1;
          hit_way_c   = WB'(k);
          hit_state_c = bus.state_ways[k*STATE_WIDTH +: STATE_WIDTH];
        end
      end
    end
    for (int unsigned k = NUM_WAYS; k > 0; k--) begin
      if (!valid_c[k-1]) inv_way_c = WB'(k-1);
    end
    full_c   = &valid_c;
    victim_c = full_c ? plru_pick(plru_q[bus.req_set]) : inv_way_c;
  end

  // Result register: loads on accept, drops after handshake, held under stall.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      resp_valid_q    <= 1'b0;
      hit_q           <= 1'b0;
      hit_way_q       <= '0;
      hit_way_state_q <= '0;
      multi_hit_q     <= 1'b0;
      valid_q         <= '0;
      full_q          <= 1'b0;
      victim_q        <= '0;
      resp_set_q      <= '0;
    end else if (accept) begin
      resp_valid_q    <= 1'b1;
      hit_q           <= hit_c;
      hit_way_q       <= hit_way_c;
      hit_way_state_q <= hit_state_c;
      multi_hit_q     <= multi_c;
      valid_q         <= valid_c;
      full_q          <= full_c;
      victim_q        <= victim_c;
      resp_set_q      <= bus.req_set;
    end else if (bus.resp_ready) begin
      resp_valid_q    <= 1'b0;
    end
  end

  // PLRU state: hit touch and write touch, flash clear takes priority.
  // When both touches land on one set the write touch is chained after the
  // hit touch so the write wins on shared nodes.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
    end else if (bus.plru_clear) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
    end else begin
      if (touch_hit && !same_set)
        plru_q[resp_set_q] <= plru_touch(plru_q[resp_set_q], hit_way_q);
      if (bus.state_tag_w_en)
        plru_q[bus.w_set] <= plru_touch(same_set ? plru_touch(plru_q[bus.w_set], hit_way_q)
                                                 : plru_q[bus.w_set], bus.way);
    end
  end

  // One-hot RAM write enable, purely combinational.
  always_comb begin
    bus.w_en = '0;
    for (int unsigned k = 0; k < NUM_WAYS; k++) begin
      bus.w_en[k] = bus.state_tag_w_en & (bus.way == WB'(k));
    end
  end
endmodule

// File: doc/icache_lookup_ctrl.md
ICACHE_LOOKUP_CTRL -- requirements
Module: icache_lookup_ctrl

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 4: associativity, legal values 2, 4, 8.
REQ-002 SHALL have parameter NUM_SETS, default 64: sets tracked for replacement, power of 2 and at least 2.
REQ-003 SHALL have parameter TAG_WIDTH, default 22: tag bits.
REQ-004 SHALL have parameter STATE_WIDTH, default 2: line-state bits.
REQ-005 SHALL have parameter I, default 2'b10: Invalid state encoding.
REQ-006 SHALL have derived widths WB = log2(NUM_WAYS) and SB = log2(NUM_SETS).
REQ-007 SHALL have these ports (name, direction, width, meaning):
- ACLK  in  1  clock.
- ARESETn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  lookup request.
- req_ready  out  1  request accepted when high with req_valid.
- req_set  in  SB  set index.
- tag_compare  in  TAG_WIDTH  CPU tag.
- tag_ways  in  NUM_WAYS*TAG_WIDTH  way k at [k*TAG_WIDTH +: TAG_WIDTH].
- state_ways  in  NUM_WAYS*STATE_WIDTH  way k at [k*STATE_WIDTH +: STATE_WIDTH].
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- hit  out  1  tag match on a non-I way.
- hit_way  out  WB  matching way.
- hit_way_state  out  STATE_WIDTH  state of hit_way.
- multi_hit  out  1  more than one way matched.
- valid  out  NUM_WAYS  bit k = state of way k is not I.
- full  out  1  all ways valid.
- victim_way  out  WB  way to replace on miss.
- state_tag_w_en  in  1  state/tag RAM write request.
- w_set  in  SB  set being written.
- way  in  WB  way being written.
- w_en  out  NUM_WAYS  one-hot per-way RAM write enable.
- plru_clear  in  1  flash-clear of all replacement state.

Function
REQ-008 SHALL assert req_ready = !resp_valid | resp_ready, combinationally.
REQ-009 SHALL accept a request on req_valid & req_ready, and SHALL present its result registered on the next cycle with resp_valid = 1 (latency 1).
REQ-010 SHALL hold resp_valid and all result outputs stable while resp_valid & !resp_ready.
REQ-011 SHALL deassert resp_valid after the handshake if no new request is accepted in the same cycle; back-to-back accepts SHALL give one result per cycle.
REQ-012 SHALL set hit when any way k has a tag equal to tag_compare and valid[k] = 1.
REQ-013 SHALL report the lowest matching index in hit_way on multiple hits, with multi_hit = 1.
REQ-014 SHALL output hit_way = 0 and hit_way_state = I on a miss.
REQ-015 SHALL set full = &valid.
REQ-016 SHALL set victim_way to the lowest-index invalid way if any way is invalid, otherwise to the tree-PLRU way of req_set, sampled at accept.
REQ-017 SHALL keep a tree-PLRU of NUM_WAYS-1 bits per set; each node bit points toward the less recently used subtree (0 = lower half).
REQ-018 SHALL touch the PLRU of the set at a completed handshake with hit = 1, for hit_way: each node bit on the path is set to point away from that way.
REQ-019 SHALL touch the PLRU of w_set for way on state_tag_w_en.
REQ-020 SHALL apply the write touch last when a hit touch and a write touch hit the same set in one cycle; different sets SHALL both update.
REQ-021 SHALL, on plru_clear, zero all PLRU bits in one cycle, overriding any touch in that cycle; in-flight results SHALL be unaffected.
REQ-022 SHALL drive w_en[k] = state_tag_w_en & (way == k) combinationally, with no latency.
REQ-023 SHALL compute victim_way for a request accepted in the same cycle as a touch from the pre-touch PLRU state.

Reset
REQ-024 SHALL, while ARESETn = 0, clear resp_valid, hit, hit_way, hit_way_state, multi_hit, valid, full, victim_way and all PLRU bits to 0, regardless of ACLK.
REQ-025 SHALL discard a result pending at reset; req_ready SHALL be 1 after reset.

Verification
REQ-026 Bench SHALL cover hit: NUM_WAYS=4, tag_w2=0x1A5, state_w2=2'b00, tag_compare=0x1A5 -> next cycle resp_valid=1, hit=1, hit_way=2, valid=4'b0100.
REQ-027 Bench SHALL cover miss on a full set: all ways valid, PLRU of set 3 = 0 -> hit=0, full=1, victim_way=0; after a hit on way 0 in set 3, the same lookup -> victim_way=2.
REQ-028 Bench SHALL cover invalid priority: state_w1=I, state_w3=I, others valid -> full=0, victim_way=1.
REQ-029 Bench SHALL cover backpressure: resp_ready=0 for 3 cycles -> req_ready=0 and outputs stable; resp_ready=1 -> handshake, with a next request accepted the same cycle.
REQ-030 Bench SHALL cover write enable and collision: state_tag_w_en=1, way=3 -> w_en=4'b1000 the same cycle; a simultaneous hit touch on way 0 and write touch on way 3 in one set -> write touch result wins.
REQ-031 Bench SHALL cover resets: ARESETn low mid-response -> resp_valid=0 immediately; plru_clear -> every full set returns victim_way=0.
